vedic_seq_mult_ctrl: RTL and testbench



---
 rtl/vedic_seq_mult_ctrl_if.sv | 25 ++
 rtl/vedic_seq_mult_ctrl.sv | 147 ++++++++++++++
 tb/tb_vedic_seq_mult_ctrl.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/vedic_seq_mult_ctrl_if.sv
// Handshake bundle for vedic_seq_mult_ctrl: operand input channel, product output channel,
// abort and busy status.
interface vedic_seq_mult_ctrl_if #(
  parameter int unsigned WIDTH = 8
) ();
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               abort;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] p;
  logic               busy;

  modport master (
    output in_valid, a, b, abort, out_ready,
    input  in_ready, out_valid, p, busy
  );

  modport slave (
    input  in_valid, a, b, abort, out_ready,
    output in_ready, out_valid, p, busy
  );
endinterface

// File: rtl/vedic_seq_mult_ctrl.sv
// Sequential WIDTH x WIDTH unsigned multiplier: one 2x2 Vedic core is fed one digit pair per
// cycle and the shifted partial products are summed into a 2*WIDTH accumulator.

module vedic_2_x_2 (
  input  logic [1:0] a_i,
  input  logic [1:0] b_i,
  output logic [3:0] p_o
);
  logic t_lo, t_hi, t_cross, c1;

  always_comb begin
    t_lo    = a_i[1] & b_i[0];
    t_hi    = a_i[0] & b_i[1];
    t_cross = a_i[1] & b_i[1];
    c1      = t_lo & t_hi;
    p_o[0]  = a_i[0] & b_i[0];
    p_o[1]  = t_lo ^ t_hi;
    p_o[2]  = t_cross ^ c1;
    p_o[3]  = t_cross & c1;
  end
endmodule

module vedic_seq_mult_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input logic                 clk,
  input logic                 rst,
  vedic_seq_mult_ctrl_if.slave bus
);
  localparam int unsigned NDIG = WIDTH / 2;
  localparam int unsigned IdxW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int unsigned PW   = 2 * WIDTH;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NDIG - 1);

  if ((WIDTH % 2 != 0) || (WIDTH < 4)) begin : g_width_check
    $error("vedic_seq_mult_ctrl: WIDTH must be even and >= 4");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [IdxW-1:0]   i_q, i_d, j_q, j_d;
  logic [PW-1:0]     acc_q, acc_d;
  logic [PW-1:0]     p_q, p_d;
  logic              in_ready_q;

  logic [1:0]        dig_a, dig_b;
  logic [3:0]        pp;
  logic [PW-1:0]     pp_shifted;

  always_comb begin
    dig_a      = a_q[2*int'(i_q) +: 2];
    dig_b      = b_q[2*int'(j_q) +: 2];
    pp_shifted = {{(PW-4){1'b0}}, pp} << (2 * (int'(i_q) + int'(j_q)));
  end

  vedic_2_x_2 u_core (
    .a_i (dig_a),
    .b_i (dig_b),
    .p_o (pp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      a_q        <= '0;
      b_q        <= '0;
      i_q        <= '0;
      j_q        <= '0;
      acc_q      <= '0;
      p_q        <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      i_q        <= i_d;
      j_q        <= j_d;
      acc_q      <= acc_d;
      p_q        <= p_d;
      // in_ready is registered from the next state so it stays low throughout reset
      in_ready_q <= (state_d == StIdle);
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    i_d     = i_q;
    j_d     = j_q;
    acc_d   = acc_q;
    p_d     = p_q;
    unique case (state_q)
      StIdle: begin
        if (!bus.abort && bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (bus.abort) begin
          acc_d   = '0;
          p_d     = '0;
          i_d     = '0;
          j_d     = '0;
          state_d = StIdle;
        end else begin
          acc_d = acc_q + pp_shifted;
          if (j_q == LastIdx) begin
            j_d = '0;
            i_d = i_q + 1'b1;
          end else begin
            j_d = j_q + 1'b1;
          end
          if ((i_q == LastIdx) && (j_q == LastIdx)) begin
            i_d     = '0;
            p_d     = acc_d;
            state_d = StDone;
          end
        end
      end
      StDone: begin
        if (bus.abort) begin
          acc_d   = '0;
          p_d     = '0;
          state_d = StIdle;
        end else if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.in_ready  = in_ready_q;
    bus.busy      = (state_q == StRun);
    bus.out_valid = (state_q == StDone);
    bus.p         = p_q;
  end
endmodule

// File: tb/tb_vedic_seq_mult_ctrl.sv
// Self-checking bench for vedic_seq_mult_ctrl: WIDTH=8 and WIDTH=4 instances, directed cases
// plus a random sweep compared against plain a*b and a fixed NDIG*NDIG latency.
module tb_vedic_seq_mult_ctrl;
  logic clk = 1'b0;
  logic rst;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  vedic_seq_mult_ctrl_if #(.WIDTH(8)) m8 ();
  vedic_seq_mult_ctrl_if #(.WIDTH(4)) m4 ();

  vedic_seq_mult_ctrl #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .bus(m8));
  vedic_seq_mult_ctrl #(.WIDTH(4)) u_dut4 (.clk(clk), .rst(rst), .bus(m4));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept8(input logic [7:0] a, input logic [7:0] b);
    m8.a        = a;
    m8.b        = b;
    m8.in_valid = 1'b1;
    tick();
    m8.in_valid = 1'b0;
  endtask

  // Counts cycles after the accept edge until out_valid; also counts cycles in RUN where the
  // block claimed ready or was not busy, while garbage is offered on the input channel.
  task automatic wait_done8(output int n, output int bad);
    n   = 0;
    bad = 0;
    while (!m8.out_valid && n < 100) begin
      if (m8.in_ready || !m8.busy) bad++;
      m8.in_valid = 1'($urandom_range(0, 1));
      m8.a        = 8'($urandom);
      m8.b        = 8'($urandom);
      tick();
      n++;
    end
    m8.in_valid = 1'b0;
  endtask

  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp_p,
                         input int unsigned hold, input string tag);
    int n, bad, bad_hold;
    accept8(a, b);
    wait_done8(n, bad);
    check_eq({tag, " latency"}, 32'(n), 32'd16);
    check_eq({tag, " busy_no_accept"}, 32'(bad), 32'd0);
    check_eq({tag, " p"}, 32'(m8.p), 32'(exp_p));
    bad_hold = 0;
    repeat (hold) begin
      m8.in_valid = 1'($urandom_range(0, 1));
      m8.a        = 8'($urandom);
      tick();
      if (!m8.out_valid || m8.p !== exp_p || m8.in_ready || m8.busy) bad_hold++;
    end
    check_eq({tag, " hold_stable"}, 32'(bad_hold), 32'd0);
    m8.in_valid  = 1'b0;
    m8.out_ready = 1'b1;
    tick();
    m8.out_ready = 1'b0;
    check_eq({tag, " out_valid_after_xfer"}, 32'(m8.out_valid), 32'd0);
    check_eq({tag, " in_ready_after_xfer"}, 32'(m8.in_ready), 32'd1);
    check_eq({tag, " p_kept"}, 32'(m8.p), 32'(exp_p));
  endtask

  initial begin
    logic [7:0] ra, rb;
    int n, bad;
    rst = 1'b1;
    m8.in_valid = 1'b0; m8.a = '0; m8.b = '0; m8.abort = 1'b0; m8.out_ready = 1'b0;
    m4.in_valid = 1'b0; m4.a = '0; m4.b = '0; m4.abort = 1'b0; m4.out_ready = 1'b0;
    repeat (3) tick();
    check_eq("rst in_ready", 32'(m8.in_ready), 32'd0);
    check_eq("rst out_valid", 32'(m8.out_valid), 32'd0);
    check_eq("rst busy", 32'(m8.busy), 32'd0);
    check_eq("rst p", 32'(m8.p), 32'd0);
    check_eq("rst4 in_ready", 32'(m4.in_ready), 32'd0);
    rst = 1'b0;
    tick();
    check_eq("post_rst in_ready", 32'(m8.in_ready), 32'd1);
    check_eq("post_rst4 in_ready", 32'(m4.in_ready), 32'd1);

    // Directed values
    run_op8(8'hFF, 8'hFF, 16'hFE01, 0, "ff_ff");
    run_op8(8'h00, 8'hA7, 16'h0000, 1, "zero_a7");
    run_op8(8'h03, 8'h02, 16'h0006, 0, "3_2");
    run_op8(8'h80, 8'h02, 16'h0100, 2, "80_2");

    // Random sweep against the arithmetic model
    for (int k = 0; k < 1000; k++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      run_op8(ra, rb, 16'(ra) * 16'(rb), $urandom_range(0, 5), "rnd");
    end

    // Abort at RUN cycle 7
    accept8(8'h5A, 8'h3C);
    repeat (6) tick();
    check_eq("abort pre busy", 32'(m8.busy), 32'd1);
    m8.abort = 1'b1;
    tick();
    m8.abort = 1'b0;
    check_eq("abort out_valid", 32'(m8.out_valid), 32'd0);
    check_eq("abort p", 32'(m8.p), 32'd0);
    check_eq("abort busy", 32'(m8.busy), 32'd0);
    check_eq("abort in_ready", 32'(m8.in_ready), 32'd1);
    run_op8(8'h12, 8'h34, 16'h03A8, 1, "after_abort");

    // Abort together with in_valid in IDLE captures nothing
    m8.abort = 1'b1; m8.in_valid = 1'b1; m8.a = 8'h77; m8.b = 8'h77;
    tick();
    m8.abort = 1'b0; m8.in_valid = 1'b0;
    check_eq("idle_abort busy", 32'(m8.busy), 32'd0);
    tick();
    check_eq("idle_abort busy2", 32'(m8.busy), 32'd0);
    check_eq("idle_abort p", 32'(m8.p), 32'h03A8);

    // Abort with out_ready in DONE: abort wins
    accept8(8'h77, 8'h11);
    wait_done8(n, bad);
    check_eq("done_abort reached", 32'(m8.out_valid), 32'd1);
    m8.abort = 1'b1; m8.out_ready = 1'b1;
    tick();
    m8.abort = 1'b0; m8.out_ready = 1'b0;
    check_eq("done_abort p", 32'(m8.p), 32'd0);
    check_eq("done_abort out_valid", 32'(m8.out_valid), 32'd0);

    // Reset at RUN cycle 10
    run_op8(8'hC3, 8'h5E, 16'(8'hC3) * 16'(8'h5E), 0, "pre_rst");
    accept8(8'hA1, 8'hB2);
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("run_rst in_ready", 32'(m8.in_ready), 32'd0);
    check_eq("run_rst busy", 32'(m8.busy), 32'd0);
    check_eq("run_rst out_valid", 32'(m8.out_valid), 32'd0);
    check_eq("run_rst p", 32'(m8.p), 32'd0);
    tick();
    check_eq("run_rst ready_after", 32'(m8.in_ready), 32'd1);
    run_op8(8'hA5, 8'h5A, 16'(8'hA5) * 16'(8'h5A), 1, "after_rst");

    // Reset together with out_ready in DONE: reset wins
    accept8(8'h9C, 8'hE7);
    wait_done8(n, bad);
    rst = 1'b1; m8.out_ready = 1'b1;
    tick();
    rst = 1'b0; m8.out_ready = 1'b0;
    check_eq("done_rst p", 32'(m8.p), 32'd0);
    check_eq("done_rst out_valid", 32'(m8.out_valid), 32'd0);
    check_eq("done_rst in_ready", 32'(m8.in_ready), 32'd0);
    tick();
    check_eq("done_rst ready_after", 32'(m8.in_ready), 32'd1);

    // WIDTH=4 instance
    m4.a = 4'hF; m4.b = 4'hF; m4.in_valid = 1'b1;
    tick();
    m4.in_valid = 1'b0;
    n = 0;
    while (!m4.out_valid && n < 50) begin tick(); n++; end
    check_eq("w4 latency", 32'(n), 32'd4);
    check_eq("w4 p_ff", 32'(m4.p), 32'h00E1);
    m4.a = 4'h9; m4.b = 4'h6; m4.in_valid = 1'b1; m4.out_ready = 1'b1;
    tick();
    m4.out_ready = 1'b0;
    check_eq("w4 b2b not_yet", 32'(m4.busy), 32'd0);
    check_eq("w4 b2b ready", 32'(m4.in_ready), 32'd1);
    tick();
    m4.in_valid = 1'b0;
    check_eq("w4 b2b accepted", 32'(m4.busy), 32'd1);
    n = 0;
    while (!m4.out_valid && n < 50) begin tick(); n++; end
    check_eq("w4 b2b latency", 32'(n), 32'd4);
    check_eq("w4 p_96", 32'(m4.p), 32'h0036);
    m4.out_ready = 1'b1;
    tick();
    m4.out_ready = 1'b0;
    check_eq("w4 out_valid_after", 32'(m4.out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
